// File: rtl/sa_layer_sequencer.sv
// sa_layer_sequencer: runs up to NUM_LAYERS conv layers back-to-back from a per-layer config table,
// latency: run_i -> layer_start_o +1 cycle; layer_done_i -> next start / done_o +2 cycles; BRAM writes +1 cycle,
// backpressure: none; table writes outside IDLE and BRAM writes during RUN are dropped and raise sticky err_o.
// Ports: cfg_* program the table (IDLE only); run_i/num_layers_i start a sequence; layer_done_i ends a layer;
//        wea_i/addra_i/dia_i are routed to data_wea_o/weight_wea_o by address MSB with registered addr/data;
//        layer_start_o plus nth_conv_o/burst_size_o/ofmap_size_o/layer_idx_o drive SA control;
//        busy_o/done_o/err_o report status.
// Optional: define SA_SEQ_PERF_EN to add perf_cycles_o (per-layer RUN cycles) and perf_total_o
//           (saturating ISSUE..DONE cycle count).
module sa_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int BURST_W    = 11,
    parameter int OFMAP_W    = 5,
    parameter int TIMEOUT    = 65535,
    localparam int IDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int NL_W      = $clog2(NUM_LAYERS) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [OFMAP_W-1:0] cfg_ofmap,
    input  logic [1:0]         cfg_conv,
    input  logic               run_i,
    input  logic [NL_W-1:0]    num_layers_i,
    input  logic               layer_done_i,
    input  logic               wea_i,
    input  logic [ADDR_W-1:0]  addra_i,
    input  logic [DATA_W-1:0]  dia_i,
    output logic               data_wea_o,
    output logic               weight_wea_o,
    output logic [ADDR_W-2:0]  bram_addr_o,
    output logic [DATA_W-1:0]  bram_di_o,
    output logic               layer_start_o,
    output logic [1:0]         nth_conv_o,
    output logic [BURST_W-1:0] burst_size_o,
    output logic [OFMAP_W-1:0] ofmap_size_o,
    output logic [IDX_W-1:0]   layer_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
`ifdef SA_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_cycles_o,
    output logic [31:0]        perf_total_o
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RUN, S_NEXT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NL_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               load_cfg;
    logic               start;
    logic               num_ok;
    logic [NL_W-1:0]    idx_inc;
    logic               wr_ok;

    logic [BURST_W-1:0] tbl_burst_q [NUM_LAYERS];
    logic [OFMAP_W-1:0] tbl_ofmap_q [NUM_LAYERS];
    logic [1:0]         tbl_conv_q  [NUM_LAYERS];

    logic [BURST_W-1:0] burst_q;
    logic [OFMAP_W-1:0] ofmap_q;
    logic [1:0]         conv_q;
    logic               data_wea_q, weight_wea_q;
    logic [ADDR_W-2:0]  addr_q;
    logic [DATA_W-1:0]  di_q;

    assign num_ok  = (num_q != '0) && (num_q <= NL_W'(NUM_LAYERS));
    assign idx_inc = NL_W'(idx_q) + NL_W'(1);
    assign wr_ok   = wea_i && (state_q != S_RUN);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        load_cfg = 1'b0;
        start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d  = S_ISSUE;
                    idx_d    = '0;
                    num_d    = num_layers_i;
                    err_d    = 1'b0;
                    load_cfg = 1'b1;
                end
            end
            S_ISSUE: begin
                // An empty or over-range layer count spends this cycle here without a
                // start pulse, so done_o still lands two cycles after run_i.
                if (!num_ok) begin
                    state_d = S_DONE;
                    if (num_q != '0) err_d = 1'b1;
                end else if (burst_q == '0) begin
                    // Never start the array on a zero-length burst.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    start   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion is checked first: a done in the timeout cycle is not an error.
                if (layer_done_i) begin
                    state_d = S_NEXT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_NEXT: begin
                if (idx_inc == num_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d    = IDX_W'(idx_inc);
                    load_cfg = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cfg_we && state_q != S_IDLE) err_d = 1'b1;
        if (wea_i && state_q == S_RUN)   err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            num_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            burst_q      <= '0;
            ofmap_q      <= '0;
            conv_q       <= '0;
            data_wea_q   <= 1'b0;
            weight_wea_q <= 1'b0;
            addr_q       <= '0;
            di_q         <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                tbl_burst_q[i] <= '0;
                tbl_ofmap_q[i] <= '0;
                tbl_conv_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Config is captured on entry to ISSUE so it is valid with the start pulse
            // and held until the next layer is issued.
            if (load_cfg) begin
                burst_q <= tbl_burst_q[idx_d];
                ofmap_q <= tbl_ofmap_q[idx_d];
                conv_q  <= tbl_conv_q[idx_d];
            end
            if (cfg_we && state_q == S_IDLE) begin
                tbl_burst_q[cfg_idx] <= cfg_burst;
                tbl_ofmap_q[cfg_idx] <= cfg_ofmap;
                tbl_conv_q[cfg_idx]  <= cfg_conv;
            end
            data_wea_q   <= wr_ok && !addra_i[ADDR_W-1];
            weight_wea_q <= wr_ok &&  addra_i[ADDR_W-1];
            if (wr_ok) begin
                addr_q <= addra_i[ADDR_W-2:0];
                di_q   <= dia_i;
            end
        end
    end

`ifdef SA_SEQ_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_total_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_total_q  <= '0;
        end else if (state_q == S_IDLE && run_i) begin
            perf_cycles_q <= '0;
            perf_total_q  <= '0;
        end else begin
            if (state_q == S_RUN && layer_done_i)
                perf_cycles_q <= 32'(cnt_q) + 32'd1;
            if (state_q != S_IDLE && perf_total_q != '1)
                perf_total_q <= perf_total_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_total_o  = perf_total_q;
`endif

    assign layer_start_o = start;
    assign nth_conv_o    = conv_q;
    assign burst_size_o  = burst_q;
    assign ofmap_size_o  = ofmap_q;
    assign layer_idx_o   = idx_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign data_wea_o    = data_wea_q;
    assign weight_wea_o  = weight_wea_q;
    assign bram_addr_o   = addr_q;
    assign bram_di_o     = di_q;

endmodule

// File: tb/tb_sa_layer_sequencer.sv
// tb_sa_layer_sequencer: directed self-checking bench for sa_layer_sequencer,
// latency: n/a (bench), inputs driven 1 time unit after the rising edge and outputs sampled there,
// backpressure: n/a.
module tb_sa_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [10:0] cfg_burst;
    logic [4:0]  cfg_ofmap;
    logic [1:0]  cfg_conv;
    logic        run_i;
    logic [2:0]  num_layers_i;
    logic        layer_done_i;
    logic        wea_i;
    logic [16:0] addra_i;
    logic [7:0]  dia_i;
    logic        data_wea_o, weight_wea_o;
    logic [15:0] bram_addr_o;
    logic [7:0]  bram_di_o;
    logic        layer_start_o;
    logic [1:0]  nth_conv_o;
    logic [10:0] burst_size_o;
    logic [4:0]  ofmap_size_o;
    logic [1:0]  layer_idx_o;
    logic        busy_o, done_o, err_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sa_layer_sequencer #(
        .NUM_LAYERS(4), .ADDR_W(17), .DATA_W(8), .BURST_W(11), .OFMAP_W(5), .TIMEOUT(100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_burst(cfg_burst), .cfg_ofmap(cfg_ofmap),
        .cfg_conv(cfg_conv), .run_i(run_i), .num_layers_i(num_layers_i),
        .layer_done_i(layer_done_i), .wea_i(wea_i), .addra_i(addra_i), .dia_i(dia_i),
        .data_wea_o(data_wea_o), .weight_wea_o(weight_wea_o), .bram_addr_o(bram_addr_o),
        .bram_di_o(bram_di_o), .layer_start_o(layer_start_o), .nth_conv_o(nth_conv_o),
        .burst_size_o(burst_size_o), .ofmap_size_o(ofmap_size_o), .layer_idx_o(layer_idx_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int i, input int b, input int o, input int c);
        cfg_we    = 1'b1;
        cfg_idx   = 2'(i);
        cfg_burst = 11'(b);
        cfg_ofmap = 5'(o);
        cfg_conv  = 2'(c);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic start_run(input int n);
        num_layers_i = 3'(n);
        run_i        = 1'b1;
        tick();
        run_i        = 1'b0;
    endtask

    int exp_b [3] = '{784, 1176, 400};
    int exp_o [3] = '{28, 10, 5};
    int exp_c [3] = '{0, 1, 2};

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_burst = '0; cfg_ofmap = '0; cfg_conv = '0;
        run_i = 1'b0; num_layers_i = '0; layer_done_i = 1'b0; wea_i = 1'b0; addra_i = '0; dia_i = '0;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_start", layer_start_o, 0);
        chk("rst_idx", layer_idx_o, 0);
        chk("rst_wea", {data_wea_o, weight_wea_o}, 0);
        rst_n = 1'b1;
        tick();

        // layer_done outside RUN is ignored
        layer_done_i = 1'b1; tick(); layer_done_i = 1'b0;
        chk("idle_done_ignored_busy", busy_o, 0);

        cfg(0, 784, 28, 0);
        cfg(1, 1176, 10, 1);
        cfg(2, 400, 5, 2);

        // three-layer sequence, each layer answered 50 cycles after its start
        start_run(3);
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("L%0d_start", l), layer_start_o, 1);
            chk($sformatf("L%0d_burst", l), burst_size_o, exp_b[l]);
            chk($sformatf("L%0d_ofmap", l), ofmap_size_o, exp_o[l]);
            chk($sformatf("L%0d_conv", l), nth_conv_o, exp_c[l]);
            chk($sformatf("L%0d_idx", l), layer_idx_o, l);
            tick();
            chk($sformatf("L%0d_start_1cyc", l), layer_start_o, 0);
            repeat (48) tick();
            tick();
            layer_done_i = 1'b1; tick(); layer_done_i = 1'b0;
            chk($sformatf("L%0d_done_lo", l), done_o, 0);
            chk($sformatf("L%0d_burst_hold", l), burst_size_o, exp_b[l]);
            tick();
        end
        chk("seq_done", done_o, 1);
        chk("seq_err", err_o, 0);
        tick();
        chk("seq_idle", busy_o, 0);

        // write routing in IDLE
        wea_i = 1'b1; addra_i = 17'h10005; dia_i = 8'hAA; tick();
        chk("wr_w_weight", weight_wea_o, 1);
        chk("wr_w_data", data_wea_o, 0);
        chk("wr_w_addr", bram_addr_o, 5);
        chk("wr_w_di", bram_di_o, 8'hAA);
        addra_i = 17'h00005; dia_i = 8'h55; tick();
        wea_i = 1'b0;
        chk("wr_d_data", data_wea_o, 1);
        chk("wr_d_weight", weight_wea_o, 0);
        chk("wr_d_addr", bram_addr_o, 5);
        chk("wr_d_di", bram_di_o, 8'h55);
        tick();
        chk("wr_off", {data_wea_o, weight_wea_o}, 0);

        // entry 1 burst 0: layer 0 runs, layer 1 aborts with error
        cfg(1, 0, 10, 1);
        start_run(2);
        chk("bz_start0", layer_start_o, 1);
        tick();
        layer_done_i = 1'b1; tick(); layer_done_i = 1'b0;
        tick();
        chk("bz_idx1", layer_idx_o, 1);
        tick();
        chk("bz_done", done_o, 1);
        chk("bz_err", err_o, 1);
        tick();
        chk("bz_idle", busy_o, 0);
        chk("bz_err_sticky", err_o, 1);

        // zero layers: no start, done two cycles after run, err cleared by run
        start_run(0);
        chk("z_start", layer_start_o, 0);
        chk("z_busy1", busy_o, 1);
        chk("z_done_early", done_o, 0);
        tick();
        chk("z_done", done_o, 1);
        chk("z_busy2", busy_o, 1);
        chk("z_err", err_o, 0);
        tick();
        chk("z_idle", busy_o, 0);

        // over-range layer count
        start_run(5);
        chk("ov_start", layer_start_o, 0);
        tick();
        chk("ov_done", done_o, 1);
        chk("ov_err", err_o, 1);
        tick();

        // timeout after 100 RUN cycles
        start_run(1);
        chk("to_start", layer_start_o, 1);
        chk("to_err_cleared", err_o, 0);
        repeat (100) tick();
        chk("to_last_run_err", err_o, 0);
        chk("to_last_run_done", done_o, 0);
        tick();
        chk("to_done", done_o, 1);
        chk("to_err", err_o, 1);
        tick();
        chk("to_idle", busy_o, 0);

        // layer_done in the timeout cycle wins
        start_run(1);
        repeat (100) tick();
        layer_done_i = 1'b1; tick(); layer_done_i = 1'b0;
        chk("tw_next_nodone", done_o, 0);
        tick();
        chk("tw_done", done_o, 1);
        chk("tw_err", err_o, 0);
        tick();

        // cfg_we during RUN is dropped and flags an error
        start_run(1);
        tick();
        cfg(0, 999, 3, 3);
        chk("cw_err", err_o, 1);
        layer_done_i = 1'b1; tick(); layer_done_i = 1'b0;
        tick();
        chk("cw_done", done_o, 1);
        tick();

        // BRAM write during RUN is dropped, then reset mid-RUN
        start_run(1);
        chk("wr_run_entry0_kept", burst_size_o, 784);
        chk("wr_run_err_clr", err_o, 0);
        tick();
        wea_i = 1'b1; addra_i = 17'h10007; dia_i = 8'h11; tick(); wea_i = 1'b0;
        chk("wr_run_wea", {data_wea_o, weight_wea_o}, 0);
        chk("wr_run_err", err_o, 1);
        chk("wr_run_busy", busy_o, 1);
        rst_n = 1'b0; tick();
        chk("mr_busy", busy_o, 0);
        chk("mr_done", done_o, 0);
        chk("mr_err", err_o, 0);
        chk("mr_cfg", {burst_size_o, ofmap_size_o, nth_conv_o}, 0);
        chk("mr_idx", layer_idx_o, 0);
        chk("mr_bram", {bram_addr_o, bram_di_o}, 0);
        rst_n = 1'b1; tick();
        chk("mr_no_done", done_o, 0);
        start_run(1);
        chk("mr_tbl_burst", burst_size_o, 0);
        chk("mr_tbl_ofmap", ofmap_size_o, 0);
        tick();
        chk("mr_tbl_done", done_o, 1);
        chk("mr_tbl_err", err_o, 1);
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
